// File: rtl/gtech_rr_arb8_if.sv
// Request/grant bundle between the clients and the round-robin arbiter.
interface gtech_rr_arb8_if;
   logic [7:0] REQ;
   logic       EN;
   logic       ANY;
   logic [7:0] GNT;
   logic       GNT_VLD;
   logic [2:0] GNT_ID;

   // Client side: drives requests and enable, observes grants.
   modport master (
      output REQ,
      output EN,
      input  ANY,
      input  GNT,
      input  GNT_VLD,
      input  GNT_ID
   );

   // Arbiter side: observes requests, drives grants.
   modport slave (
      input  REQ,
      input  EN,
      output ANY,
      output GNT,
      output GNT_VLD,
      output GNT_ID
   );
endinterface

// File: rtl/gtech_rr_arb8.sv
// Eight-client round-robin arbiter with registered one-hot grant and
// optional hold limit that forces rotation while others are waiting.
module gtech_rr_arb8 #(
   parameter int MAX_HOLD = 16
) (
   input logic             CP,
   input logic             CD,
   gtech_rr_arb8_if.slave  bus
);

   typedef enum logic {IDLE, OWNED} state_t;

   // Hold counter value at which the owner must give way.
   localparam int         LIM_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam logic [7:0] LIM   = LIM_I[7:0];

   state_t     state_q, state_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] gnt_id_q, gnt_id_d;
   logic       gnt_vld_q, gnt_vld_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] hcnt_q, hcnt_d;

   logic [7:0] others;
   logic       owner_req;
   logic       at_limit;
   logic [3:0] pick_all;
   logic [3:0] pick_oth;
   logic       grant_new;
   logic       release_gnt;
   logic [2:0] new_idx;

   // First set bit of mask searching from ptr+1 around to ptr; {found, idx}.
   function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr);
      logic       found;
      logic [2:0] idx;
      logic [2:0] cand;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         cand = ptr + 3'(k);
         if (!found && mask[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // Request detect is purely combinational so it works during reset.
   assign bus.ANY     = |bus.REQ;
   assign bus.GNT     = gnt_q;
   assign bus.GNT_VLD = gnt_vld_q;
   assign bus.GNT_ID  = gnt_id_q;

   // Next-state arbitration decision.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_vld_d   = gnt_vld_q;
      ptr_d       = ptr_q;
      hcnt_d      = hcnt_q;
      grant_new   = 1'b0;
      release_gnt = 1'b0;
      new_idx     = 3'd0;

      others    = bus.REQ & ~gnt_q;
      owner_req = |(bus.REQ & gnt_q);
      at_limit  = (MAX_HOLD != 0) && (hcnt_q >= LIM);
      pick_all  = rr_pick(bus.REQ, ptr_q);
      pick_oth  = rr_pick(others, ptr_q);

      case (state_q)
         IDLE: begin
            if (bus.EN && pick_all[3]) begin
               grant_new = 1'b1;
               new_idx   = pick_all[2:0];
            end
         end
         OWNED: begin
            if (!owner_req) begin
               // Owner let go: hand over directly or fall back to idle.
               if (bus.EN && pick_oth[3]) begin
                  grant_new = 1'b1;
                  new_idx   = pick_oth[2:0];
               end else begin
                  release_gnt = 1'b1;
               end
            end else if (bus.EN && at_limit && pick_oth[3]) begin
               grant_new = 1'b1;
               new_idx   = pick_oth[2:0];
            end else if (!(bus.EN && at_limit)) begin
               // Counter parks at the limit so a newcomer rotates in next edge.
               hcnt_d = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;
            end
         end
         default: release_gnt = 1'b1;
      endcase

      if (grant_new) begin
         state_d   = OWNED;
         gnt_d     = 8'b0000_0001 << new_idx;
         gnt_id_d  = new_idx;
         gnt_vld_d = 1'b1;
         ptr_d     = new_idx;
         hcnt_d    = 8'd0;
      end else if (release_gnt) begin
         state_d   = IDLE;
         gnt_d     = 8'd0;
         gnt_id_d  = 3'd0;
         gnt_vld_d = 1'b0;
         hcnt_d    = 8'd0;
      end
   end

   // State and registered outputs; cleared asynchronously by CD.
   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state_q   <= IDLE;
         gnt_q     <= 8'd0;
         gnt_id_q  <= 3'd0;
         gnt_vld_q <= 1'b0;
         ptr_q     <= 3'd7;
         hcnt_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
      end
   end

endmodule

// File: doc/gtech_rr_arb8.md
# gtech_rr_arb8

Eight-requester round-robin arbiter that shares one downstream resource among up to eight clients. Its request-detect term is the 8-input OR reduction of the request vector. Grants are registered and one-hot, and an owner may hold the grant while it keeps requesting. An optional hold limit forces rotation so that no client starves the others. The block sits in front of any shared bus or datapath built from the generic cell library.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one owner may hold the grant while others are waiting. 0 means no limit. Legal range is 0–255.
- CP, input, 1: clock, rising-edge.
- CD, input, 1: asynchronous active-low reset (clear). Asserting it clears all state immediately; deassertion is synchronous to CP.
- REQ, input, 8: per-client request; bit i belongs to client i. A client holds the bit high for as long as it wants the resource.
- EN, input, 1: arbitration enable. When low, no new grant is issued. An existing grant still releases normally.
- ANY, output, 1: combinational OR of REQ[7:0].
- GNT, output, 8: registered one-hot grant, or all-zero.
- GNT_VLD, output, 1: registered; equals the OR of GNT.
- GNT_ID, output, 3: registered binary index of the granted client. It is 0 when GNT_VLD is 0.

## Operation
- Two states:
  - IDLE: no grant.
  - OWNED: exactly one GNT bit is high.
- Round-robin pointer PTR (3 bits) holds the index of the last owner. Search order starts at PTR+1 (mod 8) and wraps through to PTR.
- IDLE → OWNED: on an edge where EN=1 and REQ≠0. The first requesting index in search order is granted.
- OWNED, owner's REQ bit low at the edge (release):
  - If EN=1 and another client requests, the grant passes directly to the next requester in search order, with no idle cycle.
  - Otherwise the state returns to IDLE.
- OWNED, owner still requesting:
  - The grant is retained and hold counter HCNT increments, saturating at 255.
  - When MAX_HOLD≠0, HCNT=MAX_HOLD−1 and some other client requests: forced rotation. The grant moves to the next other requester in search order.
  - If no other client requests, the owner keeps the grant and HCNT holds.
- Every grant change loads PTR with the new owner's index and clears HCNT. PTR is unchanged on release to IDLE.
- EN=0 while OWNED:
  - The owner keeps the grant while it requests; hold limit and forced rotation are suppressed.
  - On release the state goes to IDLE.
- Invariants:
  - GNT is never multi-hot.
  - GNT_ID always matches GNT.
  - The grant is never given to a client whose REQ was low at the deciding edge.

## Timing
- Reset values (asynchronous, CD low): GNT=0, GNT_VLD=0, GNT_ID=0, PTR=7 (so client 0 wins first), HCNT=0, state IDLE. ANY follows REQ even while in reset.
- Latency from REQ rising to GNT is 1 cycle: the request is sampled at edge N and GNT is valid after edge N.
- Release latency is 1 cycle: the owner's REQ is low at edge N, so its GNT is low after edge N. The next owner's GNT rises after the same edge N.
- Forced rotation timing: the owner's grant lasts MAX_HOLD cycles, then the next requester is granted at the following edge.
- MAX_HOLD=1 gives strict per-cycle rotation among active requesters.
- Reset mid-grant: all outputs drop asynchronously. After CD rises, arbitration restarts from PTR=7.
- Simultaneous owner release and new requests: new requests sampled at the same edge are eligible, the releasing owner is not, and search order applies.

## Test plan
1. Reset with REQ=8'hFF, then release CD with EN=1 → GNT=8'h01 and GNT_ID=0 one cycle later; ANY=1 throughout, including during reset.
2. REQ=8'hFF held, MAX_HOLD=4 → grants 0,1,2,…,7,0, each for exactly 4 cycles, with no gaps and no double grants.
3. REQ=8'h24 (clients 2 and 5), client 2 granted; drop REQ[2] → GNT=8'h20 on the next edge with no IDLE cycle. Then drop REQ[5] → GNT=0, GNT_VLD=0.
4. Only REQ[3] high for 40 cycles with MAX_HOLD=16 → GNT=8'h08 continuously and HCNT does not force a release.
5. Client 6 owns the grant, set EN=0 and raise REQ[1] → client 6 keeps the grant beyond MAX_HOLD. Drop REQ[6] → IDLE, with no grant to client 1 until EN=1.
6. Assert CD mid-grant of client 4 → GNT=0 immediately, without waiting for CP. After release with REQ=8'h10 → GNT=8'h10 one cycle later.
